// File: rtl/id_ex_pipe_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg_if
//   Bundle between the decode stage, the forwarding network and the ID/EX
//   pipeline register of the MiniRiscV core.
//
//   master : decode-stage / hazard-unit side (drives control, decode fields
//            and forwarding sources, observes the latched stage contents)
//   slave  : the ID/EX register itself
//
//   Signal summary
//     stall, flush, in_valid            stage control
//     ctrl_i .. rd_i                    decode fields to be latched
//     fwd_valid, fwd_rd, fwd_data       NUM_FWD forwarding sources, source k
//                                       packed at [k*RA_W +: RA_W] and
//                                       [k*XLEN +: XLEN]; k=0 is youngest
//     valid_o .. bubble_cnt_o           latched stage contents
// ---------------------------------------------------------------------------
interface id_ex_pipe_reg_if #(
   parameter int XLEN    = 32,
   parameter int CTRL_W  = 7,
   parameter int NUM_FWD = 2,
   parameter int RA_W    = 5,
   parameter int CNT_W   = 16
);
   // stage control
   logic                    stall;
   logic                    flush;
   logic                    in_valid;

   // decode fields
   logic [CTRL_W-1:0]       ctrl_i;
   logic [XLEN-1:0]         rs1_data_i;
   logic [XLEN-1:0]         rs2_data_i;
   logic [XLEN-1:0]         imm_i;
   logic [31:0]             instr_i;
   logic [RA_W-1:0]         rs1_i;
   logic [RA_W-1:0]         rs2_i;
   logic [RA_W-1:0]         rd_i;

   // forwarding sources
   logic [NUM_FWD-1:0]      fwd_valid;
   logic [NUM_FWD*RA_W-1:0] fwd_rd;
   logic [NUM_FWD*XLEN-1:0] fwd_data;

   // latched stage contents
   logic                    valid_o;
   logic [CTRL_W-1:0]       ctrl_o;
   logic [XLEN-1:0]         rs1_data_o;
   logic [XLEN-1:0]         rs2_data_o;
   logic [XLEN-1:0]         imm_o;
   logic [2:0]              func3_o;
   logic [6:0]              func7_o;
   logic [RA_W-1:0]         rs1_o;
   logic [RA_W-1:0]         rs2_o;
   logic [RA_W-1:0]         rd_o;
   logic [CNT_W-1:0]        bubble_cnt_o;

   modport master (
      output stall, flush, in_valid,
      output ctrl_i, rs1_data_i, rs2_data_i, imm_i, instr_i, rs1_i, rs2_i, rd_i,
      output fwd_valid, fwd_rd, fwd_data,
      input  valid_o, ctrl_o, rs1_data_o, rs2_data_o, imm_o, func3_o, func7_o,
      input  rs1_o, rs2_o, rd_o, bubble_cnt_o
   );

   modport slave (
      input  stall, flush, in_valid,
      input  ctrl_i, rs1_data_i, rs2_data_i, imm_i, instr_i, rs1_i, rs2_i, rd_i,
      input  fwd_valid, fwd_rd, fwd_data,
      output valid_o, ctrl_o, rs1_data_o, rs2_data_o, imm_o, func3_o, func7_o,
      output rs1_o, rs2_o, rd_o, bubble_cnt_o
   );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
//   ID/EX pipeline register of the MiniRiscV core. Latches decoded control,
//   operands, immediate, func3/func7 and register indices on every falling
//   clk edge. Operands are resolved against NUM_FWD forwarding sources by
//   comparing destination indices; source 0 is the youngest and wins.
//
//   Per falling edge the priority is flush > stall > load:
//     flush : stage becomes a bubble, bubble counter increments
//     stall : stage holds; a held valid instruction still picks up fresh
//             operand values from the forwarding sources
//     load  : valid_o <= in_valid; a non-valid load is a bubble and counts
//   The bubble counter saturates at all-ones.
//
//   Ports
//     clk   clock, state updates on the falling edge
//     rst   asynchronous, active-low; clears all state immediately
//     bus   id_ex_pipe_reg_if.slave (control, decode fields, forwarding
//           sources in; latched stage contents out)
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
   parameter int XLEN    = 32,
   parameter int CTRL_W  = 7,
   parameter int NUM_FWD = 2,
   parameter int RA_W    = 5,
   parameter int CNT_W   = 16
) (
   input logic             clk,
   input logic             rst,
   id_ex_pipe_reg_if.slave bus
);

   // ------------------------------------------------------------------
   // Helper functions
   // ------------------------------------------------------------------

   // Operand resolution: the lowest-index valid source whose destination
   // matches wins. The loop walks from the highest index down so the last
   // assignment is the highest-priority match. x0 is never forwarded.
   function automatic logic [XLEN-1:0] fwd_select(
      input logic [RA_W-1:0]         ra,
      input logic [XLEN-1:0]         dflt,
      input logic [NUM_FWD-1:0]      fv,
      input logic [NUM_FWD*RA_W-1:0] frd,
      input logic [NUM_FWD*XLEN-1:0] fd
   );
      logic [XLEN-1:0] res;
      res = dflt;
      if (ra != '0) begin
         for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fv[k] && (frd[k*RA_W +: RA_W] == ra)) begin
               res = fd[k*XLEN +: XLEN];
            end
         end
      end
      return res;
   endfunction

   // Saturating increment: all-ones is sticky.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      logic [CNT_W-1:0] one;
      one = {{(CNT_W-1){1'b0}}, 1'b1};
      return (c == {CNT_W{1'b1}}) ? c : c + one;
   endfunction

   // ------------------------------------------------------------------
   // p0: decode-side inputs and next-state selection
   // ------------------------------------------------------------------
   logic                    bubble_p0;
   logic                    hold_p0;
   logic                    load_p0;
   logic [XLEN-1:0]         rs1_fwd_p0;
   logic [XLEN-1:0]         rs2_fwd_p0;
   logic [XLEN-1:0]         rs1_held_p0;
   logic [XLEN-1:0]         rs2_held_p0;

   // Only func3/func7 are taken from the raw instruction word; the other
   // bits are already present as decoded fields.
   logic                    unused_instr_bits;
   assign unused_instr_bits = ^{bus.instr_i[24:15], bus.instr_i[11:0]};

   // next-state values
   logic                    vld_nxt;
   logic [CTRL_W-1:0]       ctrl_nxt;
   logic [XLEN-1:0]         rs1_data_nxt;
   logic [XLEN-1:0]         rs2_data_nxt;
   logic [XLEN-1:0]         imm_nxt;
   logic [2:0]              func3_nxt;
   logic [6:0]              func7_nxt;
   logic [RA_W-1:0]         rs1_nxt;
   logic [RA_W-1:0]         rs2_nxt;
   logic [RA_W-1:0]         rd_nxt;
   logic [CNT_W-1:0]        cnt_nxt;

   // ------------------------------------------------------------------
   // p1: latched ID/EX contents
   // ------------------------------------------------------------------
   logic                    vld_p1;
   logic [CTRL_W-1:0]       ctrl_p1;
   logic [XLEN-1:0]         rs1_data_p1;
   logic [XLEN-1:0]         rs2_data_p1;
   logic [XLEN-1:0]         imm_p1;
   logic [2:0]              func3_p1;
   logic [6:0]              func7_p1;
   logic [RA_W-1:0]         rs1_p1;
   logic [RA_W-1:0]         rs2_p1;
   logic [RA_W-1:0]         rd_p1;
   logic [CNT_W-1:0]        cnt_p1;

   // A bubble is produced either by a flush (which overrides a stall) or
   // by an ordinary load of a non-valid decode slot.
   assign bubble_p0 = bus.flush | (~bus.stall & ~bus.in_valid);
   assign hold_p0   = ~bus.flush & bus.stall;
   assign load_p0   = ~bus.flush & ~bus.stall & bus.in_valid;

   // Load path resolves against the incoming source indices.
   assign rs1_fwd_p0 = fwd_select(bus.rs1_i, bus.rs1_data_i,
                                  bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
   assign rs2_fwd_p0 = fwd_select(bus.rs2_i, bus.rs2_data_i,
                                  bus.fwd_valid, bus.fwd_rd, bus.fwd_data);

   // Stall path refreshes a held valid instruction against its latched
   // source indices; the held value is the fallback.
   assign rs1_held_p0 = vld_p1 ? fwd_select(rs1_p1, rs1_data_p1,
                                            bus.fwd_valid, bus.fwd_rd, bus.fwd_data)
                               : rs1_data_p1;
   assign rs2_held_p0 = vld_p1 ? fwd_select(rs2_p1, rs2_data_p1,
                                            bus.fwd_valid, bus.fwd_rd, bus.fwd_data)
                               : rs2_data_p1;

   always_comb begin
      vld_nxt      = vld_p1;
      ctrl_nxt     = ctrl_p1;
      rs1_data_nxt = rs1_data_p1;
      rs2_data_nxt = rs2_data_p1;
      imm_nxt      = imm_p1;
      func3_nxt    = func3_p1;
      func7_nxt    = func7_p1;
      rs1_nxt      = rs1_p1;
      rs2_nxt      = rs2_p1;
      rd_nxt       = rd_p1;
      cnt_nxt      = cnt_p1;

      if (bubble_p0) begin
         vld_nxt      = 1'b0;
         ctrl_nxt     = '0;
         rs1_data_nxt = '0;
         rs2_data_nxt = '0;
         imm_nxt      = '0;
         func3_nxt    = '0;
         func7_nxt    = '0;
         rs1_nxt      = '0;
         rs2_nxt      = '0;
         rd_nxt       = '0;
         cnt_nxt      = sat_inc(cnt_p1);
      end else if (hold_p0) begin
         rs1_data_nxt = rs1_held_p0;
         rs2_data_nxt = rs2_held_p0;
      end else if (load_p0) begin
         vld_nxt      = 1'b1;
         ctrl_nxt     = bus.ctrl_i;
         rs1_data_nxt = rs1_fwd_p0;
         rs2_data_nxt = rs2_fwd_p0;
         imm_nxt      = bus.imm_i;
         func3_nxt    = bus.instr_i[14:12];
         func7_nxt    = bus.instr_i[31:25];
         rs1_nxt      = bus.rs1_i;
         rs2_nxt      = bus.rs2_i;
         rd_nxt       = bus.rd_i;
      end
   end

   // Falling-edge register; reset clears everything immediately, which also
   // cancels any stall that was holding the stage.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1      <= 1'b0;
         ctrl_p1     <= '0;
         rs1_data_p1 <= '0;
         rs2_data_p1 <= '0;
         imm_p1      <= '0;
         func3_p1    <= '0;
         func7_p1    <= '0;
         rs1_p1      <= '0;
         rs2_p1      <= '0;
         rd_p1       <= '0;
         cnt_p1      <= '0;
      end else begin
         vld_p1      <= vld_nxt;
         ctrl_p1     <= ctrl_nxt;
         rs1_data_p1 <= rs1_data_nxt;
         rs2_data_p1 <= rs2_data_nxt;
         imm_p1      <= imm_nxt;
         func3_p1    <= func3_nxt;
         func7_p1    <= func7_nxt;
         rs1_p1      <= rs1_nxt;
         rs2_p1      <= rs2_nxt;
         rd_p1       <= rd_nxt;
         cnt_p1      <= cnt_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.valid_o      = vld_p1;
   assign bus.ctrl_o       = ctrl_p1;
   assign bus.rs1_data_o   = rs1_data_p1;
   assign bus.rs2_data_o   = rs2_data_p1;
   assign bus.imm_o        = imm_p1;
   assign bus.func3_o      = func3_p1;
   assign bus.func7_o      = func7_p1;
   assign bus.rs1_o        = rs1_p1;
   assign bus.rs2_o        = rs2_p1;
   assign bus.rd_o         = rd_p1;
   assign bus.bubble_cnt_o = cnt_p1;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

   localparam int XLEN    = 32;
   localparam int CTRL_W  = 7;
   localparam int NUM_FWD = 2;
   localparam int RA_W    = 5;
   localparam int CNT_W   = 16;
   localparam int SAT_W   = 4;

   typedef struct packed {
      logic              valid;
      logic [CTRL_W-1:0] ctrl;
      logic [XLEN-1:0]   rs1d;
      logic [XLEN-1:0]   rs2d;
      logic [XLEN-1:0]   imm;
      logic [2:0]        f3;
      logic [6:0]        f7;
      logic [RA_W-1:0]   rs1;
      logic [RA_W-1:0]   rs2;
      logic [RA_W-1:0]   rd;
      logic [CNT_W-1:0]  cnt;
   } exp_t;

   logic clk;
   logic rst;
   logic rst_sat;

   int   vectors;
   int   miscompares;

   exp_t            mdl;
   exp_t            sb[$];
   logic [SAT_W-1:0] sat_sb[$];

   id_ex_pipe_reg_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .NUM_FWD(NUM_FWD),
                       .RA_W(RA_W), .CNT_W(CNT_W)) ifm ();
   id_ex_pipe_reg_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .NUM_FWD(NUM_FWD),
                       .RA_W(RA_W), .CNT_W(SAT_W)) ifs ();

   id_ex_pipe_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .NUM_FWD(NUM_FWD),
                    .RA_W(RA_W), .CNT_W(CNT_W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (ifm)
   );

   id_ex_pipe_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .NUM_FWD(NUM_FWD),
                    .RA_W(RA_W), .CNT_W(SAT_W)) u_sat (
      .clk (clk),
      .rst (rst_sat),
      .bus (ifs)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [XLEN-1:0] fwd_pick(input logic [RA_W-1:0] ra,
                                               input logic [XLEN-1:0] dflt);
      if (ra == 0) return dflt;
      for (int k = 0; k < NUM_FWD; k++)
         if (ifm.fwd_valid[k] && ifm.fwd_rd[k*RA_W +: RA_W] == ra)
            return ifm.fwd_data[k*XLEN +: XLEN];
      return dflt;
   endfunction

   function automatic exp_t model_next(input exp_t m);
      exp_t n;
      n = m;
      if (ifm.flush) begin
         n = '0;
         n.cnt = (m.cnt == 16'hFFFF) ? m.cnt : m.cnt + 16'd1;
      end else if (ifm.stall) begin
         if (m.valid) begin
            n.rs1d = fwd_pick(m.rs1, m.rs1d);
            n.rs2d = fwd_pick(m.rs2, m.rs2d);
         end
      end else if (!ifm.in_valid) begin
         n = '0;
         n.cnt = (m.cnt == 16'hFFFF) ? m.cnt : m.cnt + 16'd1;
      end else begin
         n.valid = 1'b1;
         n.ctrl  = ifm.ctrl_i;
         n.rs1d  = fwd_pick(ifm.rs1_i, ifm.rs1_data_i);
         n.rs2d  = fwd_pick(ifm.rs2_i, ifm.rs2_data_i);
         n.imm   = ifm.imm_i;
         n.f3    = ifm.instr_i[14:12];
         n.f7    = ifm.instr_i[31:25];
         n.rs1   = ifm.rs1_i;
         n.rs2   = ifm.rs2_i;
         n.rd    = ifm.rd_i;
      end
      return n;
   endfunction

   function automatic exp_t sample();
      exp_t o;
      o.valid = ifm.valid_o;
      o.ctrl  = ifm.ctrl_o;
      o.rs1d  = ifm.rs1_data_o;
      o.rs2d  = ifm.rs2_data_o;
      o.imm   = ifm.imm_o;
      o.f3    = ifm.func3_o;
      o.f7    = ifm.func7_o;
      o.rs1   = ifm.rs1_o;
      o.rs2   = ifm.rs2_o;
      o.rd    = ifm.rd_o;
      o.cnt   = ifm.bubble_cnt_o;
      return o;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic set_id(input logic v, input logic [CTRL_W-1:0] c,
                         input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                         input logic [XLEN-1:0] im, input logic [31:0] ins,
                         input logic [RA_W-1:0] r1, input logic [RA_W-1:0] r2,
                         input logic [RA_W-1:0] rd);
      ifm.in_valid = v;  ifm.ctrl_i = c;
      ifm.rs1_data_i = d1; ifm.rs2_data_i = d2; ifm.imm_i = im;
      ifm.instr_i = ins; ifm.rs1_i = r1; ifm.rs2_i = r2; ifm.rd_i = rd;
   endtask

   task automatic set_fwd(input logic [1:0] fv,
                          input logic [RA_W-1:0] rd0, input logic [XLEN-1:0] d0,
                          input logic [RA_W-1:0] rd1, input logic [XLEN-1:0] d1);
      ifm.fwd_valid = fv;
      ifm.fwd_rd    = {rd1, rd0};
      ifm.fwd_data  = {d1, d0};
   endtask

   // Push model expectation, then let the falling edge happen and settle.
   task automatic cycle();
      mdl = model_next(mdl);
      sb.push_back(mdl);
      @(negedge clk);
      #2;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      exp_t obs;
      rst = 1'b0;
      ifm.stall = 0; ifm.flush = 0;
      set_id(0, '0, '0, '0, '0, '0, '0, '0, '0);
      set_fwd(2'b00, '0, '0, '0, '0);
      mdl = '0;
      @(negedge clk);
      #2;
      obs = sample();
      vectors++;
      if (obs !== exp_t'('0)) begin
         miscompares++;
         $display("FAIL reset_state: got %h expected %h", obs, exp_t'('0));
      end
      #1 rst = 1'b1;
   endtask

   task automatic test_load_nofwd();
      exp_t obs, e;
      set_id(1, 7'h23, 32'h1111_0001, 32'h2222_0002, 32'h0000_0010,
             32'h00A2_8233, 5'd5, 5'd10, 5'd4);
      set_fwd(2'b00, 5'd5, 32'hDEAD, 5'd10, 32'hBEEF);
      cycle();
      e = sb.pop_front();
      obs = sample();
      vectors++;
      if (obs !== e) begin
         miscompares++;
         $display("FAIL load_nofwd: got %h expected %h", obs, e);
      end
      vectors++;
      if ({obs.f3, obs.f7, obs.rd, obs.rs1d, obs.valid} !== {3'd0, 7'd0, 5'd4, 32'h1111_0001, 1'b1}) begin
         miscompares++;
         $display("FAIL load_fields: got f3=%h f7=%h rd=%0d rs1d=%h v=%b expected 0 0 4 11110001 1",
                  obs.f3, obs.f7, obs.rd, obs.rs1d, obs.valid);
      end
   endtask

   task automatic test_fwd_priority();
      exp_t obs, e;
      set_id(1, 7'h40, 32'h9999, 32'h7777, 32'h5, 32'h0062_8233, 5'd5, 5'd6, 5'd4);
      set_fwd(2'b11, 5'd5, 32'hAAAA, 5'd5, 32'hBBBB);
      cycle();
      e = sb.pop_front();
      obs = sample();
      vectors++;
      if (obs !== e || obs.rs1d !== 32'hAAAA || obs.rs2d !== 32'h7777) begin
         miscompares++;
         $display("FAIL fwd_both: got %h expected %h (rs1d must be AAAA)", obs, e);
      end
      // Only the older source matches: rs2 from source 1, rs1 from regfile
      set_fwd(2'b11, 5'd9, 32'hAAAA, 5'd6, 32'hBBBB);
      cycle();
      e = sb.pop_front();
      obs = sample();
      vectors++;
      if (obs !== e || obs.rs1d !== 32'h9999 || obs.rs2d !== 32'hBBBB) begin
         miscompares++;
         $display("FAIL fwd_src1: got %h expected %h", obs, e);
      end
      // Matching source with fwd_valid low is ignored
      set_fwd(2'b10, 5'd5, 32'hAAAA, 5'd7, 32'hBBBB);
      cycle();
      e = sb.pop_front();
      obs = sample();
      vectors++;
      if (obs !== e || obs.rs1d !== 32'h9999) begin
         miscompares++;
         $display("FAIL fwd_invalid: got %h expected %h", obs, e);
      end
   endtask

   task automatic test_x0();
      exp_t obs, e;
      set_id(1, 7'h11, 32'h3, 32'h0, 32'h1, 32'h0002_8033, 5'd5, 5'd0, 5'd0);
      set_fwd(2'b01, 5'd0, 32'h1234, 5'd0, 32'h5678);
      cycle();
      e = sb.pop_front();
      obs = sample();
      vectors++;
      if (obs !== e || obs.rs2d !== 32'h0) begin
         miscompares++;
         $display("FAIL x0_no_fwd: got %h expected %h (rs2d must be 0)", obs, e);
      end
   endtask

   task automatic test_stall_refresh();
      exp_t obs, e;
      set_id(1, 7'h15, 32'h70, 32'h71, 32'h77, 32'h4000_5133, 5'd7, 5'd8, 5'd3);
      set_fwd(2'b00, '0, '0, '0, '0);
      cycle();
      e = sb.pop_front();
      obs = sample();
      vectors++;
      if (obs !== e) begin
         miscompares++;
         $display("FAIL stall_setup: got %h expected %h", obs, e);
      end
      ifm.stall = 1;
      set_id(1, 7'h7F, 32'hFFFF, 32'hEEEE, 32'hCCCC, 32'hFFFF_FFFF, 5'd7, 5'd8, 5'd9);
      set_fwd(2'b10, 5'd7, 32'h99, 5'd7, 32'h55);
      cycle();
      e = sb.pop_front();
      obs = sample();
      vectors++;
      if (obs !== e || obs.rs1d !== 32'h55 || obs.ctrl !== 7'h15 ||
          obs.imm !== 32'h77 || obs.rd !== 5'd3 || obs.rs2d !== 32'h71) begin
         miscompares++;
         $display("FAIL stall_refresh: got %h expected %h", obs, e);
      end
      // Stall with no matching source: everything holds
      set_fwd(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
      cycle();
      e = sb.pop_front();
      obs = sample();
      vectors++;
      if (obs !== e || obs.rs1d !== 32'h55) begin
         miscompares++;
         $display("FAIL stall_hold: got %h expected %h", obs, e);
      end
   endtask

   task automatic test_flush_stall();
      exp_t obs, e;
      logic [CNT_W-1:0] prev;
      prev = mdl.cnt;
      ifm.stall = 1; ifm.flush = 1;
      cycle();
      e = sb.pop_front();
      obs = sample();
      vectors++;
      if (obs !== e || obs.valid !== 1'b0 || obs.rs1d !== '0 ||
          obs.cnt !== prev + 16'd1) begin
         miscompares++;
         $display("FAIL flush_stall: got %h expected %h", obs, e);
      end
      // Reload something, then reset asynchronously between edges
      ifm.stall = 0; ifm.flush = 0;
      set_id(1, 7'h33, 32'h10, 32'h20, 32'h30, 32'h0000_7033, 5'd1, 5'd2, 5'd3);
      cycle();
      void'(sb.pop_front());
      ifm.stall = 1;
      #1 rst = 1'b0;
      #1;
      mdl = '0;
      obs = sample();
      vectors++;
      if (obs !== exp_t'('0)) begin
         miscompares++;
         $display("FAIL async_reset: got %h expected %h", obs, exp_t'('0));
      end
      #1 rst = 1'b1;
      // Stall was aborted by reset; first edge after release loads
      ifm.stall = 0;
      cycle();
      e = sb.pop_front();
      obs = sample();
      vectors++;
      if (obs !== e || obs.valid !== 1'b1) begin
         miscompares++;
         $display("FAIL post_reset_load: got %h expected %h", obs, e);
      end
   endtask

   task automatic test_back_to_back();
      exp_t obs, e;
      for (int i = 0; i < 40; i++) begin
         ifm.flush = ($urandom_range(0, 9) == 0);
         ifm.stall = ($urandom_range(0, 3) == 0);
         set_id(1'($urandom_range(0, 3) != 0), 7'($urandom), $urandom, $urandom,
                $urandom, $urandom, 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
         set_fwd(2'($urandom), 5'($urandom_range(0, 3)), $urandom,
                 5'($urandom_range(0, 3)), $urandom);
         cycle();
         e = sb.pop_front();
         obs = sample();
         vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL b2b[%0d]: got %h expected %h", i, obs, e);
         end
      end
      ifm.flush = 0; ifm.stall = 0;
   endtask

   task automatic test_saturation();
      logic [SAT_W-1:0] es;
      #1 rst_sat = 1'b1;
      for (int i = 0; i < 20; i++) begin
         sat_sb.push_back((i + 1 >= 15) ? 4'd15 : 4'(i + 1));
         @(negedge clk);
         #2;
         es = sat_sb.pop_front();
         vectors++;
         if (ifs.bubble_cnt_o !== es || ifs.valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL saturation[%0d]: got cnt=%0d v=%b expected cnt=%0d v=0",
                     i, ifs.bubble_cnt_o, ifs.valid_o, es);
         end
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_sat = 1'b0;
      ifs.stall = 0; ifs.flush = 0; ifs.in_valid = 0;
      ifs.ctrl_i = '0; ifs.rs1_data_i = '0; ifs.rs2_data_i = '0; ifs.imm_i = '0;
      ifs.instr_i = '0; ifs.rs1_i = '0; ifs.rs2_i = '0; ifs.rd_i = '0;
      ifs.fwd_valid = '0; ifs.fwd_rd = '0; ifs.fwd_data = '0;

      test_reset();
      test_load_nofwd();
      test_fwd_priority();
      test_x0();
      test_stall_refresh();
      test_flush_stall();
      test_back_to_back();
      test_saturation();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
